// File: rtl/systolic_feeder_if.sv
// Upstream vector handshake for systolic_feeder: one ROWS*N-bit vector per accept.
interface systolic_feeder_if #(
   parameter int unsigned N    = 32,
   parameter int unsigned ROWS = 4
) ();
   logic              in_valid;
   logic              in_ready;
   logic [ROWS*N-1:0] in_data;
   logic              in_last;

   modport master (output in_valid, output in_data, output in_last, input in_ready);
   modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/systolic_feeder.sv
// Skews each accepted vector into a diagonal wavefront (lane r delayed r cycles) for the array.
// Optional macro SYSTOLIC_FEEDER_BUBBLE_ZERO_EN: bubble slots carry zero data instead of held data.
module systolic_feeder #(
   parameter int unsigned N     = 32,
   parameter int unsigned ROWS  = 4,
   parameter int unsigned MAX_K = 256
) (
   input  logic                         clk,
   input  logic                         rst,
   systolic_feeder_if.slave             in_if,
   output logic [ROWS*N-1:0]            feed_data_o,
   output logic [ROWS-1:0]              feed_valid_o,
   output logic                         busy_o,
   output logic                         done_o,
   output logic [$clog2(MAX_K+1)-1:0]   k_count_o
);
   localparam int unsigned KW        = $clog2(MAX_K + 1);
   localparam int unsigned FW        = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned FlushLast = (ROWS > 1) ? ROWS - 2 : 0;

   typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;

   state_e          state_q;
   logic [FW-1:0]   flush_cnt_q;
   logic [KW-1:0]   k_count_q;
   logic            done_q;
   logic            accept;

   assign in_if.in_ready = (state_q != StFlush);
   assign busy_o         = (state_q != StIdle);
   assign done_o         = done_q;
   assign k_count_o      = k_count_q;
   assign accept         = in_if.in_valid && in_if.in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         flush_cnt_q <= '0;
         k_count_q   <= '0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle, StStream: begin
               if (accept) begin
                  if (state_q == StIdle) begin
                     k_count_q <= KW'(1);
                  end else if (k_count_q != KW'(MAX_K)) begin
                     k_count_q <= k_count_q + 1'b1;
                  end
                  if (!in_if.in_last) begin
                     state_q <= StStream;
                  end else if (ROWS == 1) begin
                     state_q <= StIdle;
                     done_q  <= 1'b1;
                  end else begin
                     state_q     <= StFlush;
                     flush_cnt_q <= '0;
                  end
               end
            end
            StFlush: begin
               // Leaving FLUSH is the edge where the last vector lands in the final lane.
               if (flush_cnt_q == FW'(FlushLast)) begin
                  state_q <= StIdle;
                  done_q  <= 1'b1;
               end else begin
                  flush_cnt_q <= flush_cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_lane
      logic [N-1:0] data_q [0:r];
      logic [r:0]   vld_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= '0;
            for (int s = 0; s <= r; s++) data_q[s] <= '0;
         end else begin
            vld_q[0] <= accept;
            for (int s = 1; s <= r; s++) begin
               vld_q[s]  <= vld_q[s-1];
               data_q[s] <= data_q[s-1];
            end
            if (accept) begin
               data_q[0] <= in_if.in_data[r*N +: N];
            end
`ifdef SYSTOLIC_FEEDER_BUBBLE_ZERO_EN
            else begin
               data_q[0] <= '0;
            end
`endif
         end
      end

      assign feed_data_o[r*N +: N] = data_q[r];
      assign feed_valid_o[r]       = vld_q[r];
   end
endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: a ROWS=4 instance driven through directed phases,
// plus a ROWS=1 instance for the single-lane corner.
module tb_systolic_feeder;
   localparam int unsigned N = 32;

   typedef struct {
      int          lane;
      int          cyc;
      logic [31:0] data;
   } lane_exp_t;

   typedef struct {
      int cyc;
      int k;
   } done_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   lane_exp_t lane_q[$];
   done_exp_t done_q[$];

   // Bubble window (relative to lane 0) checked by the monitor.
   bit bub_en = 1'b0;
   int bub_lo = 0;
   int bub_hi = 0;
   int bub_k  = 0;

   systolic_feeder_if #(.N(N), .ROWS(4)) if_a ();
   systolic_feeder_if #(.N(N), .ROWS(1)) if_b ();

   logic [4*N-1:0] fd_a;
   logic [3:0]     fv_a;
   logic           busy_a, done_a;
   logic [8:0]     k_a;
   logic [N-1:0]   fd_b;
   logic [0:0]     fv_b;
   logic           busy_b, done_b;
   logic [8:0]     k_b;

   systolic_feeder #(.N(N), .ROWS(4), .MAX_K(256)) dut_a (
      .clk          (clk),
      .rst          (rst),
      .in_if        (if_a),
      .feed_data_o  (fd_a),
      .feed_valid_o (fv_a),
      .busy_o       (busy_a),
      .done_o       (done_a),
      .k_count_o    (k_a)
   );

   systolic_feeder #(.N(N), .ROWS(1), .MAX_K(256)) dut_b (
      .clk          (clk),
      .rst          (rst),
      .in_if        (if_b),
      .feed_data_o  (fd_b),
      .feed_valid_o (fv_b),
      .busy_o       (busy_b),
      .done_o       (done_b),
      .k_count_o    (k_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
      end
   endtask

   // Present inputs for the next edge, then move to just after that edge.
   task automatic step(input bit v, input bit last, input int k);
      if_a.in_valid = v;
      if_a.in_last  = last;
      for (int r = 0; r < 4; r++) if_a.in_data[r*N +: N] = 32'(10 * k + r);
      @(posedge clk);
      #1;
   endtask

   task automatic exp_lane(input int t, input int k, input int r);
      lane_q.push_back('{lane: r, cyc: t + r, data: 32'(10 * k + r)});
   endtask

   task automatic exp_vec(input int t, input int k);
      for (int r = 0; r < 4; r++) exp_lane(t, k, r);
   endtask

   task automatic exp_done(input int t, input int k);
      done_q.push_back('{cyc: t, k: k});
   endtask

   always @(negedge clk) begin
      int        idx;
      done_exp_t d;
      logic [31:0] bub_exp;
      for (int r = 0; r < 4; r++) begin
         if (fv_a[r] === 1'b1) begin
            idx = -1;
            for (int i = 0; i < lane_q.size(); i++) begin
               if (idx < 0 && lane_q[i].lane == r) idx = i;
            end
            if (idx < 0) begin
               checks++;
               failures++;
               $display("FAIL lane%0d_unexpected_valid cyc=%0d actual=valid data=%0d required=no valid",
                        r, cyc, fd_a[r*N +: N]);
            end else begin
               chk($sformatf("lane%0d_cycle", r), 64'(cyc), 64'(lane_q[idx].cyc));
               chk($sformatf("lane%0d_data", r), 64'(fd_a[r*N +: N]), 64'(lane_q[idx].data));
               lane_q.delete(idx);
            end
         end else if (bub_en && cyc >= bub_lo + r && cyc <= bub_hi + r) begin
`ifdef SYSTOLIC_FEEDER_BUBBLE_ZERO_EN
            bub_exp = '0;
`else
            bub_exp = 32'(10 * bub_k + r);
`endif
            chk($sformatf("lane%0d_bubble_data", r), 64'(fd_a[r*N +: N]), 64'(bub_exp));
         end
      end
      if (done_a === 1'b1) begin
         if (done_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done_unexpected cyc=%0d actual=1 required=0", cyc);
         end else begin
            d = done_q.pop_front();
            chk("done_cycle", 64'(cyc), 64'(d.cyc));
            chk("done_k_count", 64'(k_a), 64'(d.k));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      if_a.in_valid = 1'b1;  // must not be accepted while rst is high
      if_a.in_last  = 1'b0;
      if_a.in_data  = '1;
      if_b.in_valid = 1'b0;
      if_b.in_last  = 1'b0;
      if_b.in_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state after 5 idle cycles.
      repeat (5) step(1'b0, 1'b0, 0);
      chk("rst_feed_valid", 64'(fv_a), 64'(0));
      chk("rst_feed_data", 64'(fd_a[63:0]), 64'(0));
      chk("rst_in_ready", 64'(if_a.in_ready), 64'(1));
      chk("rst_busy", 64'(busy_a), 64'(0));
      chk("rst_done", 64'(done_a), 64'(0));
      chk("rst_k_count", 64'(k_a), 64'(0));

      // Three back-to-back vectors, last on k=2.
      t = cyc + 1;
      exp_vec(t, 0);
      exp_vec(t + 1, 1);
      exp_vec(t + 2, 2);
      exp_done(t + 5, 3);
      step(1'b1, 1'b0, 0);
      chk("stream_busy", 64'(busy_a), 64'(1));
      step(1'b1, 1'b0, 1);
      step(1'b1, 1'b1, 2);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("flush_in_ready_%0d", i), 64'(if_a.in_ready), 64'(0));
         step(1'b0, 1'b0, 0);
      end
      chk("after_flush_in_ready", 64'(if_a.in_ready), 64'(1));
      chk("after_flush_busy", 64'(busy_a), 64'(0));
      chk("tile_k_count", 64'(k_a), 64'(3));
      repeat (3) step(1'b0, 1'b0, 0);
      chk("idle_k_count_hold", 64'(k_a), 64'(3));

      // Gaps in in_valid: vector, two bubbles, vector+last.
      t = cyc + 1;
      exp_vec(t, 5);
      exp_vec(t + 3, 6);
      exp_done(t + 6, 2);
      bub_k  = 5;
      bub_lo = t + 1;
      bub_hi = t + 2;
      bub_en = 1'b1;
      step(1'b1, 1'b0, 5);
      step(1'b0, 1'b0, 99);
      step(1'b0, 1'b0, 98);
      step(1'b1, 1'b1, 6);
      repeat (6) step(1'b0, 1'b0, 0);
      bub_en = 1'b0;

      // in_valid held through FLUSH: one-vector tile, then new tile taken in the done cycle.
      t = cyc + 1;
      exp_vec(t, 7);
      exp_done(t + 3, 1);
      exp_vec(t + 4, 8);
      exp_vec(t + 5, 9);
      exp_done(t + 8, 2);
      step(1'b1, 1'b1, 7);
      chk("hold_flush_in_ready", 64'(if_a.in_ready), 64'(0));
      repeat (4) step(1'b1, 1'b0, 8);
      chk("new_tile_k_count", 64'(k_a), 64'(1));
      step(1'b1, 1'b1, 9);
      repeat (6) step(1'b0, 1'b0, 0);

      // Reset mid-stream with two vectors in flight.
      t = cyc + 1;
      exp_lane(t, 11, 0);
      exp_lane(t, 11, 1);
      exp_lane(t + 1, 12, 0);
      step(1'b1, 1'b0, 11);
      step(1'b1, 1'b0, 12);
      rst = 1'b1;
      step(1'b1, 1'b0, 13);
      rst = 1'b0;
      chk("midrst_feed_valid", 64'(fv_a), 64'(0));
      chk("midrst_busy", 64'(busy_a), 64'(0));
      chk("midrst_k_count", 64'(k_a), 64'(0));
      chk("midrst_done", 64'(done_a), 64'(0));
      chk("midrst_in_ready", 64'(if_a.in_ready), 64'(1));
      repeat (6) step(1'b0, 1'b0, 0);

      // ROWS=1: single vector with last gives valid and done together next cycle.
      chk("r1_in_ready_pre", 64'(if_b.in_ready), 64'(1));
      if_b.in_valid = 1'b1;
      if_b.in_last  = 1'b1;
      if_b.in_data  = 32'd42;
      @(posedge clk);
      #1;
      if_b.in_valid = 1'b0;
      if_b.in_last  = 1'b0;
      chk("r1_feed_valid", 64'(fv_b), 64'(1));
      chk("r1_done", 64'(done_b), 64'(1));
      chk("r1_feed_data", 64'(fd_b), 64'(42));
      chk("r1_k_count", 64'(k_b), 64'(1));
      chk("r1_in_ready", 64'(if_b.in_ready), 64'(1));
      chk("r1_busy", 64'(busy_b), 64'(0));
      @(posedge clk);
      #1;
      chk("r1_feed_valid_after", 64'(fv_b), 64'(0));
      chk("r1_done_after", 64'(done_b), 64'(0));

      chk("lane_queue_drained", 64'(lane_q.size()), 64'(0));
      chk("done_queue_drained", 64'(done_q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
